id_ex_stage: RTL and testbench
==============================

// Module: id_ex_stage
// PURPOSE
//   ID/EX pipeline stage feeding ALU_64_bit. Registers decoded operands and control each cycle.
//   Decodes the 4-bit ALUOp and forwards results from EX/MEM and MEM/WB onto the ALU operands.
//   Detects load-use hazards and inserts bubbles. Honours downstream stall and branch flush.
// PARAMETERS
//   XLEN   64  datapath width (operands, PC, imm, results)
//   REGW    5  register index width
// PORTS
//   clk              in   1      rising-edge clock
//   reset            in   1      synchronous, active-high
//   stall            in   1      downstream hold; freezes this stage
//   flush            in   1      branch/redirect kill; loads bubble
//   id_valid         in   1      ID holds a real instruction
//   id_pc,id_imm     in   XLEN   PC; sign-extended immediate
//   id_rs1_data      in   XLEN   register-file read port 1
//   id_rs2_data      in   XLEN   register-file read port 2
//   id_rs1,id_rs2    in   REGW   source indices
//   id_rd            in   REGW   destination index
//   id_uses_rs2      in   1      instruction reads rs2 (R-type/store/branch)
//   id_alu_src       in   1      0: B=rs2, 1: B=imm
//   id_alu_class     in   2      00 ld/sd add, 01 branch sub, 10 R-type, 11 I-type
//   id_funct3        in   3      instr[14:12]
//   id_f7b5          in   1      instr[30]
//   id_ctrl          in   5      {branch,mem_to_reg,mem_write,mem_read,reg_write}
//   exmem_reg_write  in   1      EX/MEM writes rd
//   exmem_rd         in   REGW   EX/MEM destination
//   exmem_result     in   XLEN   EX/MEM ALU result
//   memwb_reg_write  in   1      MEM/WB writes rd
//   memwb_rd         in   REGW   MEM/WB destination
//   memwb_result     in   XLEN   MEM/WB writeback value
//   hazard_stall     out  1      comb.; ID/IF must hold this cycle
//   ex_valid         out  1      registered instruction valid
//   ex_ctrl          out  5      registered id_ctrl (0 in bubble)
//   ex_alu_op        out  4      ALUOp to ALU_64_bit (registered)
//   ex_alu_a         out  XLEN   forwarded operand A (comb. from regs)
//   ex_alu_b         out  XLEN   forwarded/imm operand B (comb.)
//   ex_store_data    out  XLEN   forwarded rs2 for stores
//   ex_rd            out  REGW   registered destination
//   ex_pc,ex_imm     out  XLEN   registered PC / immediate
// BEHAVIOUR
//   Reset: all registers 0 -> ex_valid=0, ex_ctrl=0, ex_alu_op=4'b0010, data/index outputs 0.
//   Update priority per edge: reset > flush (bubble) > stall (hold) > hazard_stall (bubble) > load ID.
//   Bubble: valid=0, ctrl=0, alu_op=ADD, other fields don't-care (implementation zeroes them).
//   Latency 1 cycle ID->EX; forwarding mux is combinational on registered rs1/rs2 and live results.
//   ALUOp: class00->0010; 01->0110; 10: f3 000 ->0010/0110 by f7b5, 111->0000, 110->0001, 001->1111;
//     11: 000->0010 (f7b5 ignored), 111->0000, 110->0001, 001->1111; unlisted f3 -> 0010.
//   Forward per source: exmem match (reg_write, rd!=0, rd==rs) wins over memwb match; else regfile.
//   Index 0 never forwarded; x0 operand is the registered value.
//   ex_alu_b = alu_src ? imm : fwd_rs2; if alu_op==1111, B masked to B[5:0], upper bits 0.
//   ex_store_data = fwd_rs2 always, independent of alu_src.
//   hazard_stall = id_valid & ex_valid & ex_ctrl.mem_read & ex_rd!=0 &
//     (ex_rd==id_rs1 | (id_uses_rs2 & ex_rd==id_rs2)).
//   hazard_stall forced 0 while reset; with flush it is ignored (flush wins).
//   stall held N cycles: outputs stable; forwarding still tracks live exmem/memwb inputs.
// CONFIGURATION
//   IDEX_FORWARDING_EN defined: forwarding as above.
//   Undefined: operands come straight from registered regfile data. hazard_stall also fires for
//     any rs1/rs2 (per id_uses_rs2) match, rd!=0, against ex_rd (ex_valid & reg_write),
//     exmem_rd or memwb_rd (their reg_write).
// TESTING
//   Reset held 2 cycles -> ex_valid=0, ex_ctrl=0, ex_alu_op=0010, hazard_stall=0.
//   R-type f3=000 f7b5=1, rs1=10, rs2=3 -> next cycle op=0110, A=10, B=3.
//   (EN) reg rs1=5; exmem rd5=0xAA, memwb rd5=0xBB -> A=0xAA; drop exmem -> 0xBB; rs1=0 -> regval.
//   EX holds ld x7; ID rs2=7 uses_rs2=1 -> hazard_stall=1 now; next edge ex_valid=0, ex_ctrl=0.
//   stall=1 3 cycles -> outputs unchanged; stall+flush same edge -> bubble.
//   I-type f3=001 alu_src=1 imm=0x47 -> op=1111, B=0x07.

Source files
------------

// File: rtl/id_ex_stage_if.sv
// ID/EX stage bus: decoded ID fields, downstream stall/flush, the live
// EX/MEM and MEM/WB results used for forwarding, and the registered EX outputs.
// master = pipeline/control side, slave = the id_ex_stage register.
interface id_ex_stage_if #(
    parameter int unsigned XLEN = 64,
    parameter int unsigned REGW = 5
);
    logic            stall;
    logic            flush;

    logic            id_valid;
    logic [XLEN-1:0] id_pc;
    logic [XLEN-1:0] id_imm;
    logic [XLEN-1:0] id_rs1_data;
    logic [XLEN-1:0] id_rs2_data;
    logic [REGW-1:0] id_rs1;
    logic [REGW-1:0] id_rs2;
    logic [REGW-1:0] id_rd;
    logic            id_uses_rs2;
    logic            id_alu_src;
    logic [1:0]      id_alu_class;
    logic [2:0]      id_funct3;
    logic            id_f7b5;
    logic [4:0]      id_ctrl;

    logic            exmem_reg_write;
    logic [REGW-1:0] exmem_rd;
    logic [XLEN-1:0] exmem_result;
    logic            memwb_reg_write;
    logic [REGW-1:0] memwb_rd;
    logic [XLEN-1:0] memwb_result;

    logic            hazard_stall;
    logic            ex_valid;
    logic [4:0]      ex_ctrl;
    logic [3:0]      ex_alu_op;
    logic [XLEN-1:0] ex_alu_a;
    logic [XLEN-1:0] ex_alu_b;
    logic [XLEN-1:0] ex_store_data;
    logic [REGW-1:0] ex_rd;
    logic [XLEN-1:0] ex_pc;
    logic [XLEN-1:0] ex_imm;

    modport master (
        output stall, flush,
        output id_valid, id_pc, id_imm, id_rs1_data, id_rs2_data,
        output id_rs1, id_rs2, id_rd, id_uses_rs2, id_alu_src,
        output id_alu_class, id_funct3, id_f7b5, id_ctrl,
        output exmem_reg_write, exmem_rd, exmem_result,
        output memwb_reg_write, memwb_rd, memwb_result,
        input  hazard_stall, ex_valid, ex_ctrl, ex_alu_op,
        input  ex_alu_a, ex_alu_b, ex_store_data, ex_rd, ex_pc, ex_imm
    );

    modport slave (
        input  stall, flush,
        input  id_valid, id_pc, id_imm, id_rs1_data, id_rs2_data,
        input  id_rs1, id_rs2, id_rd, id_uses_rs2, id_alu_src,
        input  id_alu_class, id_funct3, id_f7b5, id_ctrl,
        input  exmem_reg_write, exmem_rd, exmem_result,
        input  memwb_reg_write, memwb_rd, memwb_result,
        output hazard_stall, ex_valid, ex_ctrl, ex_alu_op,
        output ex_alu_a, ex_alu_b, ex_store_data, ex_rd, ex_pc, ex_imm
    );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register feeding ALU_64_bit.
// Registers decoded operands/control, decodes ALUOp, detects load-use hazards
// (inserting bubbles) and honours downstream stall and branch flush.
// Build option: define IDEX_FORWARDING_EN to forward EX/MEM and MEM/WB results
// onto the ALU operands; without it operands come from the registered regfile
// data and hazard_stall also covers every in-flight RAW dependence.
module id_ex_stage #(
    parameter int unsigned XLEN = 64,
    parameter int unsigned REGW = 5
) (
    input logic           clk,
    input logic           reset,
    id_ex_stage_if.slave  bus
);

    typedef enum logic [3:0] {
        ALU_AND = 4'b0000,
        ALU_OR  = 4'b0001,
        ALU_ADD = 4'b0010,
        ALU_SUB = 4'b0110,
        ALU_SLL = 4'b1111
    } alu_op_e;

    typedef enum logic [1:0] {
        CLS_MEM    = 2'b00,
        CLS_BRANCH = 2'b01,
        CLS_RTYPE  = 2'b10,
        CLS_ITYPE  = 2'b11
    } alu_class_e;

    // id_ctrl = {branch, mem_to_reg, mem_write, mem_read, reg_write}
    localparam int unsigned CTRL_REG_WRITE = 0;
    localparam int unsigned CTRL_MEM_READ  = 1;
    localparam int unsigned SHAMT_W        = 6;

    typedef struct packed {
        logic            valid;
        logic [4:0]      ctrl;
        alu_op_e         alu_op;
        logic            alu_src;
        logic [REGW-1:0] rs1;
        logic [REGW-1:0] rs2;
        logic [REGW-1:0] rd;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] rs1_data;
        logic [XLEN-1:0] rs2_data;
    } stage_t;

    function automatic stage_t bubble();
        stage_t s;
        s        = '0;
        s.alu_op = ALU_ADD;
        return s;
    endfunction

    function automatic alu_op_e decode_alu_op(input alu_class_e cls,
                                              input logic [2:0] f3,
                                              input logic       f7b5);
        alu_op_e op;
        op = ALU_ADD;
        case (cls)
            CLS_MEM:    op = ALU_ADD;
            CLS_BRANCH: op = ALU_SUB;
            default: begin
                case (f3)
                    3'b000:  op = (cls == CLS_RTYPE && f7b5) ? ALU_SUB : ALU_ADD;
                    3'b111:  op = ALU_AND;
                    3'b110:  op = ALU_OR;
                    3'b001:  op = ALU_SLL;
                    default: op = ALU_ADD;
                endcase
            end
        endcase
        return op;
    endfunction

    // rd is a live producer for the instruction in ID if it is non-zero and
    // matches a source that instruction actually reads.
    function automatic logic src_match(input logic [REGW-1:0] rd,
                                       input logic [REGW-1:0] rs1,
                                       input logic [REGW-1:0] rs2,
                                       input logic            uses_rs2);
        return (rd != '0) && ((rd == rs1) || (uses_rs2 && (rd == rs2)));
    endfunction

    stage_t          stage_q, stage_d;
    logic            load_use;
    logic            raw_hazard;
    logic            hazard;
    logic [XLEN-1:0] fwd_rs1, fwd_rs2;
    logic [XLEN-1:0] b_sel, alu_b;

    // Hazard detection against the instruction currently in EX (and, without
    // forwarding, against EX/MEM and MEM/WB as well).
    always_comb begin
        load_use = bus.id_valid && stage_q.valid && stage_q.ctrl[CTRL_MEM_READ] &&
                   src_match(stage_q.rd, bus.id_rs1, bus.id_rs2, bus.id_uses_rs2);
        raw_hazard = 1'b0;
`ifndef IDEX_FORWARDING_EN
        raw_hazard = bus.id_valid && (
            (stage_q.valid && stage_q.ctrl[CTRL_REG_WRITE] &&
             src_match(stage_q.rd, bus.id_rs1, bus.id_rs2, bus.id_uses_rs2)) ||
            (bus.exmem_reg_write &&
             src_match(bus.exmem_rd, bus.id_rs1, bus.id_rs2, bus.id_uses_rs2)) ||
            (bus.memwb_reg_write &&
             src_match(bus.memwb_rd, bus.id_rs1, bus.id_rs2, bus.id_uses_rs2)));
`endif
        hazard = !reset && (load_use || raw_hazard);
    end

    // Next-state selection: flush > stall (hold) > hazard bubble > load from ID.
    always_comb begin
        stage_d = stage_q;
        if (bus.flush) begin
            stage_d = bubble();
        end else if (bus.stall) begin
            stage_d = stage_q;
        end else if (hazard) begin
            stage_d = bubble();
        end else begin
            stage_d.valid    = bus.id_valid;
            stage_d.ctrl     = bus.id_ctrl;
            stage_d.alu_op   = decode_alu_op(alu_class_e'(bus.id_alu_class),
                                             bus.id_funct3, bus.id_f7b5);
            stage_d.alu_src  = bus.id_alu_src;
            stage_d.rs1      = bus.id_rs1;
            stage_d.rs2      = bus.id_rs2;
            stage_d.rd       = bus.id_rd;
            stage_d.pc       = bus.id_pc;
            stage_d.imm      = bus.id_imm;
            stage_d.rs1_data = bus.id_rs1_data;
            stage_d.rs2_data = bus.id_rs2_data;
        end
    end

    // Pipeline register with synchronous reset to a bubble.
    always_ff @(posedge clk) begin
        if (reset) begin
            stage_q <= bubble();
        end else begin
            stage_q <= stage_d;
        end
    end

    // Operand select: forwarding tracks the live EX/MEM and MEM/WB results
    // even while the stage is held; EX/MEM is the younger value and wins.
    always_comb begin
        fwd_rs1 = stage_q.rs1_data;
        fwd_rs2 = stage_q.rs2_data;
`ifdef IDEX_FORWARDING_EN
        if (bus.exmem_reg_write && (bus.exmem_rd != '0) && (bus.exmem_rd == stage_q.rs1)) begin
            fwd_rs1 = bus.exmem_result;
        end else if (bus.memwb_reg_write && (bus.memwb_rd != '0) &&
                     (bus.memwb_rd == stage_q.rs1)) begin
            fwd_rs1 = bus.memwb_result;
        end
        if (bus.exmem_reg_write && (bus.exmem_rd != '0) && (bus.exmem_rd == stage_q.rs2)) begin
            fwd_rs2 = bus.exmem_result;
        end else if (bus.memwb_reg_write && (bus.memwb_rd != '0) &&
                     (bus.memwb_rd == stage_q.rs2)) begin
            fwd_rs2 = bus.memwb_result;
        end
`endif
        b_sel = stage_q.alu_src ? stage_q.imm : fwd_rs2;
        alu_b = b_sel;
        // Shifts only consume a 6-bit shamt; clear the rest so the ALU sees a clean amount.
        if (stage_q.alu_op == ALU_SLL) begin
            alu_b = {{(XLEN - SHAMT_W){1'b0}}, b_sel[SHAMT_W-1:0]};
        end
    end

`ifndef IDEX_FORWARDING_EN
    logic unused_fwd_results;
    assign unused_fwd_results = ^{bus.exmem_result, bus.memwb_result};
`endif

    assign bus.hazard_stall  = hazard;
    assign bus.ex_valid      = stage_q.valid;
    assign bus.ex_ctrl       = stage_q.ctrl;
    assign bus.ex_alu_op     = stage_q.alu_op;
    assign bus.ex_alu_a      = fwd_rs1;
    assign bus.ex_alu_b      = alu_b;
    assign bus.ex_store_data = fwd_rs2;
    assign bus.ex_rd         = stage_q.rd;
    assign bus.ex_pc         = stage_q.pc;
    assign bus.ex_imm        = stage_q.imm;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed vectors with literal
// expectations, plus a per-cycle comparison against a behavioural model of
// the instruction held in EX.
module tb_id_ex_stage;
    localparam int unsigned XLEN = 64;
    localparam int unsigned REGW = 5;
`ifdef IDEX_FORWARDING_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    id_ex_stage_if #(.XLEN(XLEN), .REGW(REGW)) bus ();
    id_ex_stage #(.XLEN(XLEN), .REGW(REGW)) dut (.clk(clk), .reset(reset), .bus(bus));

    int unsigned n_vec = 0;
    int unsigned n_err = 0;
    bit          chk   = 1'b0;

    // Raw ID fields of the instruction the model believes sits in EX.
    typedef struct {
        bit        valid;
        bit [4:0]  ctrl;
        bit [1:0]  cls;
        bit [2:0]  f3;
        bit        f7b5;
        bit        alu_src;
        bit [4:0]  rs1, rs2, rd;
        bit [63:0] pc, imm, d1, d2;
    } ins_t;

    ins_t ex;

    function automatic ins_t bub();
        ins_t b;
        b = '{default: 0};
        return b;
    endfunction

    function automatic bit [3:0] op_of(input ins_t i);
        if (i.cls == 2'd0) return 4'b0010;
        if (i.cls == 2'd1) return 4'b0110;
        case (i.f3)
            3'd0:    return (i.cls == 2'd2 && i.f7b5) ? 4'b0110 : 4'b0010;
            3'd7:    return 4'b0000;
            3'd6:    return 4'b0001;
            3'd1:    return 4'b1111;
            default: return 4'b0010;
        endcase
    endfunction

    function automatic bit [63:0] fwd(input bit [4:0] rs, input bit [63:0] rf);
        if (!FWD || rs == 0) return rf;
        if (bus.exmem_reg_write && bus.exmem_rd == rs) return bus.exmem_result;
        if (bus.memwb_reg_write && bus.memwb_rd == rs) return bus.memwb_result;
        return rf;
    endfunction

    function automatic bit dep(input bit [4:0] rd);
        return rd != 0 && (rd == bus.id_rs1 || (bus.id_uses_rs2 && rd == bus.id_rs2));
    endfunction

    function automatic bit model_hazard();
        bit h;
        h = bus.id_valid && ex.valid && ex.ctrl[1] && dep(ex.rd);
        if (!FWD)
            h = h || (bus.id_valid && ((ex.valid && ex.ctrl[0] && dep(ex.rd)) ||
                                       (bus.exmem_reg_write && dep(bus.exmem_rd)) ||
                                       (bus.memwb_reg_write && dep(bus.memwb_rd))));
        return !reset && h;
    endfunction

    function automatic bit [63:0] exp_b();
        bit [63:0] b;
        b = ex.alu_src ? ex.imm : fwd(ex.rs2, ex.d2);
        if (op_of(ex) == 4'b1111) b = b % 64;
        return b;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    // Model update on the clock edge, using its own hazard decision.
    always @(posedge clk) begin
        bit h;
        h = model_hazard();
        if (reset || bus.flush) ex = bub();
        else if (bus.stall) ex = ex;
        else if (h) ex = bub();
        else begin
            ex.valid = bus.id_valid;   ex.ctrl = bus.id_ctrl;
            ex.cls = bus.id_alu_class; ex.f3 = bus.id_funct3; ex.f7b5 = bus.id_f7b5;
            ex.alu_src = bus.id_alu_src;
            ex.rs1 = bus.id_rs1; ex.rs2 = bus.id_rs2; ex.rd = bus.id_rd;
            ex.pc = bus.id_pc;   ex.imm = bus.id_imm;
            ex.d1 = bus.id_rs1_data; ex.d2 = bus.id_rs2_data;
        end
    end

    // Per-cycle comparison mid-cycle, away from the active edge.
    always @(negedge clk) begin
        if (chk) begin
            if (!bus.flush) check("m_hazard", bus.hazard_stall, model_hazard());
            check("m_valid", bus.ex_valid, ex.valid);
            check("m_ctrl", bus.ex_ctrl, ex.ctrl);
            check("m_op", bus.ex_alu_op, op_of(ex));
            check("m_rd", bus.ex_rd, ex.rd);
            check("m_pc", bus.ex_pc, ex.pc);
            check("m_imm", bus.ex_imm, ex.imm);
            check("m_a", bus.ex_alu_a, fwd(ex.rs1, ex.d1));
            check("m_b", bus.ex_alu_b, exp_b());
            check("m_store", bus.ex_store_data, fwd(ex.rs2, ex.d2));
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic settle();
        @(negedge clk); #1;
    endtask

    task automatic drive_id(input logic v, input logic [1:0] cls, input logic [2:0] f3,
                            input logic f7b5, input logic src, input logic u2,
                            input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                            input logic [63:0] d1, input logic [63:0] d2,
                            input logic [63:0] imm, input logic [63:0] pc,
                            input logic [4:0] ctrl);
        bus.id_valid = v;       bus.id_alu_class = cls; bus.id_funct3 = f3;
        bus.id_f7b5 = f7b5;     bus.id_alu_src = src;   bus.id_uses_rs2 = u2;
        bus.id_rs1 = rs1;       bus.id_rs2 = rs2;       bus.id_rd = rd;
        bus.id_rs1_data = d1;   bus.id_rs2_data = d2;
        bus.id_imm = imm;       bus.id_pc = pc;         bus.id_ctrl = ctrl;
    endtask

    task automatic idle();
        drive_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic drive_fwd(input logic ew, input logic [4:0] erd, input logic [63:0] eres,
                             input logic mw, input logic [4:0] mrd, input logic [63:0] mres);
        bus.exmem_reg_write = ew; bus.exmem_rd = erd; bus.exmem_result = eres;
        bus.memwb_reg_write = mw; bus.memwb_rd = mrd; bus.memwb_result = mres;
    endtask

    localparam logic [4:0] C_ALU = 5'b00001;
    localparam logic [4:0] C_LD  = 5'b01011;

    initial begin
        // Reset with an otherwise-hazardous ID/EX-MEM pairing present.
        reset = 1'b1; bus.stall = 1'b0; bus.flush = 1'b0;
        drive_id(1, 2'b10, 0, 0, 0, 1, 4, 0, 9, 0, 0, 0, 0, C_ALU);
        drive_fwd(1, 4, 64'h44, 0, 0, 0);
        tick(); chk = 1'b1; tick(); settle();
        check("rst_valid", bus.ex_valid, 1'b0);
        check("rst_ctrl", bus.ex_ctrl, 5'd0);
        check("rst_op", bus.ex_alu_op, 4'b0010);
        check("rst_hazard", bus.hazard_stall, 1'b0);
        reset = 1'b0;
        drive_fwd(0, 0, 0, 0, 0, 0);

        // R-type sub x3 = x1 - x2.
        drive_id(1, 2'b10, 3'd0, 1, 0, 1, 1, 2, 3, 64'd10, 64'd3, 0, 64'h100, C_ALU);
        tick(); settle();
        check("rsub_op", bus.ex_alu_op, 4'b0110);
        check("rsub_a", bus.ex_alu_a, 64'd10);
        check("rsub_b", bus.ex_alu_b, 64'd3);

        // addi with f7b5 set, rs1 = x5, then forwarding while held.
        drive_id(1, 2'b11, 3'd0, 1, 1, 0, 5, 0, 6, 64'h11, 0, 64'd1, 64'h104, C_ALU);
        tick(); settle();
        check("addi_op", bus.ex_alu_op, 4'b0010);
        check("addi_b", bus.ex_alu_b, 64'd1);
        bus.stall = 1'b1; idle();
        drive_fwd(1, 5, 64'hAA, 1, 5, 64'hBB); #1;
        check("fwd_exmem", bus.ex_alu_a, FWD ? 64'hAA : 64'h11);
        drive_fwd(0, 5, 64'hAA, 1, 5, 64'hBB); #1;
        check("fwd_memwb", bus.ex_alu_a, FWD ? 64'hBB : 64'h11);
        tick(); settle();
        check("fwd_hold_a", bus.ex_alu_a, FWD ? 64'hBB : 64'h11);
        check("fwd_hold_pc", bus.ex_pc, 64'h104);
        bus.stall = 1'b0;
        drive_fwd(1, 0, 64'hCC, 1, 0, 64'hDD);
        drive_id(1, 2'b11, 3'd0, 0, 1, 0, 0, 0, 8, 64'h123, 0, 64'd2, 64'h108, C_ALU);
        tick(); settle();
        check("x0_a", bus.ex_alu_a, 64'h123);
        check("x0_b", bus.ex_alu_b, 64'd2);

        // Load-use: ld x7, then and x9 = x1 & x7.
        drive_fwd(0, 0, 0, 0, 0, 0);
        drive_id(1, 2'b00, 3'd3, 0, 1, 0, 2, 0, 7, 64'h1000, 0, 64'd8, 64'h10C, C_LD);
        tick(); settle();
        check("ld_op", bus.ex_alu_op, 4'b0010);
        check("ld_b", bus.ex_alu_b, 64'd8);
        drive_id(1, 2'b10, 3'd7, 0, 0, 1, 1, 7, 9, 64'hF0, 64'h3C, 0, 64'h110, C_ALU); #1;
        check("lu_hazard", bus.hazard_stall, 1'b1);
        tick(); settle();
        check("lu_bub_valid", bus.ex_valid, 1'b0);
        check("lu_bub_ctrl", bus.ex_ctrl, 5'd0);
        check("lu_bub_op", bus.ex_alu_op, 4'b0010);
        check("lu_clear", bus.hazard_stall, 1'b0);
        tick(); settle();
        check("and_op", bus.ex_alu_op, 4'b0000);
        check("and_a", bus.ex_alu_a, 64'hF0);
        check("and_pc", bus.ex_pc, 64'h110);

        // rs2 match on an instruction that does not read rs2: no hazard.
        drive_id(1, 2'b00, 3'd3, 0, 1, 0, 2, 0, 7, 64'h1000, 0, 64'd8, 64'h114, C_LD);
        tick(); settle();
        drive_id(1, 2'b11, 3'd6, 0, 1, 0, 1, 7, 10, 64'h2, 0, 64'h5, 64'h118, C_ALU); #1;
        check("nors2_hazard", bus.hazard_stall, 1'b0);
        tick(); settle();
        check("ori_op", bus.ex_alu_op, 4'b0001);

        // Load to x0 never blocks.
        drive_id(1, 2'b00, 3'd3, 0, 1, 0, 2, 0, 0, 64'h1000, 0, 64'd8, 64'h11C, C_LD);
        tick(); settle();
        drive_id(1, 2'b10, 3'd0, 0, 0, 1, 0, 0, 11, 0, 0, 0, 64'h120, C_ALU); #1;
        check("x0ld_hazard", bus.hazard_stall, 1'b0);
        tick(); settle();
        check("x0ld_valid", bus.ex_valid, 1'b1);

        // Downstream stall for three cycles, then stall+flush together.
        bus.stall = 1'b1;
        drive_id(1, 2'b10, 3'd7, 0, 0, 1, 3, 4, 15, 64'h9, 64'h9, 0, 64'h200, C_ALU);
        for (int i = 0; i < 3; i++) begin
            tick(); settle();
            check("stall_pc", bus.ex_pc, 64'h120);
        end
        bus.flush = 1'b1;
        tick(); settle();
        check("flush_valid", bus.ex_valid, 1'b0);
        check("flush_op", bus.ex_alu_op, 4'b0010);
        bus.flush = 1'b0; bus.stall = 1'b0;

        // Shifts: slli imm 0x47 -> shamt 7; sll with wide rs2 masked, store path unmasked.
        drive_id(1, 2'b11, 3'd1, 0, 1, 0, 1, 0, 12, 64'h5, 0, 64'h47, 64'h124, C_ALU);
        tick(); settle();
        check("slli_op", bus.ex_alu_op, 4'b1111);
        check("slli_b", bus.ex_alu_b, 64'h7);
        drive_id(1, 2'b10, 3'd1, 0, 0, 1, 1, 2, 13, 64'h5, 64'hFFFF_FFFF_FFFF_FFC5, 0, 64'h128, C_ALU);
        tick(); settle();
        check("sll_b", bus.ex_alu_b, 64'h5);
        check("sll_store", bus.ex_store_data, 64'hFFFF_FFFF_FFFF_FFC5);

        // Store and branch.
        drive_id(1, 2'b00, 3'd3, 0, 1, 1, 1, 2, 0, 64'h8, 64'h55, 64'd16, 64'h12C, 5'b00100);
        tick(); settle();
        check("sd_b", bus.ex_alu_b, 64'd16);
        check("sd_store", bus.ex_store_data, 64'h55);
        drive_id(1, 2'b01, 3'd0, 0, 0, 1, 1, 2, 0, 64'd9, 64'd4, 0, 64'h130, 5'b10000);
        tick(); settle();
        check("br_op", bus.ex_alu_op, 4'b0110);
        check("br_b", bus.ex_alu_b, 64'd4);

        // Flush wins over a pending load-use hazard.
        drive_id(1, 2'b00, 3'd3, 0, 1, 0, 2, 0, 7, 64'h1000, 0, 64'd8, 64'h134, C_LD);
        tick(); settle();
        bus.flush = 1'b1;
        drive_id(1, 2'b10, 3'd0, 0, 0, 1, 7, 1, 14, 0, 0, 0, 64'h138, C_ALU);
        tick(); settle();
        check("flushhz_valid", bus.ex_valid, 1'b0);
        bus.flush = 1'b0;

        // Dependence on EX/MEM only: forwarded when enabled, stalled otherwise.
        idle(); tick(); settle();
        drive_fwd(1, 9, 64'h77, 0, 0, 0);
        drive_id(1, 2'b10, 3'd0, 0, 0, 1, 9, 1, 14, 64'h1, 64'h2, 0, 64'h140, C_ALU); #1;
        check("exmem_hazard", bus.hazard_stall, FWD ? 1'b0 : 1'b1);
        tick(); settle();
        check("exmem_valid", bus.ex_valid, FWD ? 1'b1 : 1'b0);
        check("exmem_a", bus.ex_alu_a, FWD ? 64'h77 : 64'h0);

        idle(); drive_fwd(0, 0, 0, 0, 0, 0);
        tick(); settle();
        chk = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Hard time bound so the run always ends.
    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, got running, expected finished");
        $fatal(1);
    end
endmodule
